// File: rtl/ma_cvxif_pkg.sv
// Shared widths, opcode and record types for the CVXIF matrix offload path.
package ma_cvxif_pkg;

  localparam int unsigned MA_XLEN   = 32;
  localparam int unsigned MA_ID_W   = 3;
  localparam logic [6:0]  MA_OPCODE = 7'b0001011;

  typedef struct packed {
    logic [31:0]        instr;
    logic [MA_XLEN-1:0] rs1;
    logic [MA_XLEN-1:0] rs2;
    logic [MA_ID_W-1:0] id;
    logic               committed;
    logic               killed;
  } ma_offload_entry_t;

  typedef struct packed {
    logic [MA_ID_W-1:0] id;
    logic [MA_XLEN-1:0] data;
    logic               we;
  } ma_result_t;

endpackage

// File: rtl/ma_result_slice.sv
// One-entry valid/ready register; accepts a new word in the cycle the old one drains.
module ma_result_slice #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ma_cvxif_offload_queue.sv
// CVXIF offload queue: decodes custom-0 ops, holds them until commit, dispatches in order.
module ma_cvxif_offload_queue #(
  parameter int unsigned XLEN      = ma_cvxif_pkg::MA_XLEN,
  parameter int unsigned ID_W      = ma_cvxif_pkg::MA_ID_W,
  parameter int unsigned DEPTH     = 4,
  parameter logic [6:0]  MA_OPCODE = ma_cvxif_pkg::MA_OPCODE
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            acc_valid_o,
  input  logic            acc_ready_i,
  output logic [31:0]     acc_instr_o,
  output logic [XLEN-1:0] acc_rs1_o,
  output logic [XLEN-1:0] acc_rs2_o,
  output logic [ID_W-1:0] acc_id_o,
  input  logic            accres_valid_i,
  output logic            accres_ready_o,
  input  logic [ID_W-1:0] accres_id_i,
  input  logic [XLEN-1:0] accres_data_i,
  input  logic            accres_we_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [XLEN-1:0] result_data_o,
  output logic            result_we_o,
  output logic            busy_o
);

  import ma_cvxif_pkg::*;

  localparam int unsigned   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  ma_offload_entry_t mem_q [DEPTH];
  ma_offload_entry_t mem_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, cmt_q, cmt_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  ma_offload_entry_t head_e, cmt_e, new_e;
  logic accept, enq, pop, cmt_open, cmt_hit, cmt_byp;

  assign accept            = (issue_instr_i[6:0] == MA_OPCODE);
  assign issue_accept_o    = accept;
  assign issue_writeback_o = accept && (issue_instr_i[11:7] != 5'd0);
  assign issue_ready_o     = !accept || (cnt_q < CNT_MAX);
  assign enq               = issue_valid_i && issue_ready_o && accept;

  assign head_e      = mem_q[head_q];
  assign acc_valid_o = vld_q[head_q] && head_e.committed && !head_e.killed;
  assign acc_instr_o = head_e.instr;
  assign acc_rs1_o   = head_e.rs1;
  assign acc_rs2_o   = head_e.rs2;
  assign acc_id_o    = head_e.id;
  // Killed entries drain without a handshake, one per cycle.
  assign pop = vld_q[head_q] && (head_e.killed || (head_e.committed && acc_ready_i));

  // The commit slot only counts as open while its entry is still unresolved;
  // when every entry is resolved the slot is empty and a same-cycle enqueue can take the commit.
  assign cmt_e    = mem_q[cmt_q];
  assign cmt_open = vld_q[cmt_q] && !cmt_e.committed && !cmt_e.killed;
  assign cmt_hit  = commit_valid_i && cmt_open && (cmt_e.id == commit_id_i);
  assign cmt_byp  = commit_valid_i && !vld_q[cmt_q] && enq && (tail_q == cmt_q)
                    && (issue_id_i == commit_id_i);

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cmt_d  = cmt_q;
    cnt_d  = cnt_q;
    new_e  = '{instr:     issue_instr_i,
               rs1:       issue_rs1_i,
               rs2:       issue_rs2_i,
               id:        issue_id_i,
               committed: cmt_byp && !commit_kill_i,
               killed:    cmt_byp && commit_kill_i};

    if (enq) begin
      mem_d[tail_q] = new_e;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_ONE;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_ONE;
    end
    if (cmt_hit) begin
      if (commit_kill_i) mem_d[cmt_q].killed    = 1'b1;
      else               mem_d[cmt_q].committed = 1'b1;
      cmt_d = cmt_q + PTR_ONE;
    end else if (cmt_byp) begin
      cmt_d = cmt_q + PTR_ONE;
    end

    case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cmt_q  <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cmt_q  <= cmt_d;
      cnt_q  <= cnt_d;
    end
  end

  ma_result_t res_in, res_out;

  assign res_in = '{id: accres_id_i, data: accres_data_i, we: accres_we_i};

  ma_result_slice #(
    .T (ma_result_t)
  ) u_result (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (accres_valid_i),
    .in_ready_o  (accres_ready_o),
    .in_data_i   (res_in),
    .out_valid_o (result_valid_o),
    .out_ready_i (result_ready_i),
    .out_data_o  (res_out)
  );

  assign result_id_o   = res_out.id;
  assign result_data_o = res_out.data;
  assign result_we_o   = res_out.we;

  assign busy_o = (cnt_q != '0) || result_valid_o;

endmodule

// File: tb/tb_ma_cvxif_offload_queue.sv
// Directed bench for the CVXIF offload queue with hand-computed expectations.
module tb_ma_cvxif_offload_queue;

  logic        clk;
  logic        rst_ni;
  logic        issue_valid_i, issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [31:0] issue_rs1_i, issue_rs2_i;
  logic [2:0]  issue_id_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i, commit_kill_i;
  logic [2:0]  commit_id_i;
  logic        acc_valid_o, acc_ready_i;
  logic [31:0] acc_instr_o, acc_rs1_o, acc_rs2_o;
  logic [2:0]  acc_id_o;
  logic        accres_valid_i, accres_ready_o, accres_we_i;
  logic [2:0]  accres_id_i;
  logic [31:0] accres_data_i;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [2:0]  result_id_o;
  logic [31:0] result_data_o;
  logic        busy_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ma_cvxif_offload_queue #(
    .XLEN      (32),
    .ID_W      (3),
    .DEPTH     (4),
    .MA_OPCODE (7'b0001011)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .issue_id_i        (issue_id_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .acc_valid_o       (acc_valid_o),
    .acc_ready_i       (acc_ready_i),
    .acc_instr_o       (acc_instr_o),
    .acc_rs1_o         (acc_rs1_o),
    .acc_rs2_o         (acc_rs2_o),
    .acc_id_o          (acc_id_o),
    .accres_valid_i    (accres_valid_i),
    .accres_ready_o    (accres_ready_o),
    .accres_id_i       (accres_id_i),
    .accres_data_i     (accres_data_i),
    .accres_we_i       (accres_we_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_we_o       (result_we_o),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; issue_id_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    acc_ready_i = 1'b0;
    accres_valid_i = 1'b0; accres_id_i = '0; accres_data_i = '0; accres_we_i = 1'b0;
    result_ready_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    settle();
    check("rst_acc_valid", acc_valid_o, 0);
    check("rst_result_valid", result_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_issue_ready", issue_ready_o, 1);

    // Single custom op, rd=0, committed afterwards
    acc_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_instr_i = 32'h0000_100B; issue_id_i = 3'd2;
    issue_rs1_i = 32'd5; issue_rs2_i = 32'd7;
    settle();
    check("s1_accept", issue_accept_o, 1);
    check("s1_writeback", issue_writeback_o, 0);
    check("s1_ready", issue_ready_o, 1);
    tick();
    issue_valid_i = 1'b0;
    check("s1_wait_commit", acc_valid_o, 0);
    check("s1_busy", busy_o, 1);
    commit_valid_i = 1'b1; commit_id_i = 3'd2; commit_kill_i = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    check("s1_acc_valid", acc_valid_o, 1);
    check("s1_acc_rs1", acc_rs1_o, 5);
    check("s1_acc_rs2", acc_rs2_o, 7);
    check("s1_acc_id", acc_id_o, 2);
    check("s1_acc_instr", acc_instr_o, 32'h0000_100B);
    tick();
    check("s1_popped", acc_valid_o, 0);
    check("s1_idle", busy_o, 0);

    // Non-custom op completes immediately and is not queued
    issue_valid_i = 1'b1; issue_instr_i = 32'h0000_0033; issue_id_i = 3'd5;
    settle();
    check("s2_ready", issue_ready_o, 1);
    check("s2_accept", issue_accept_o, 0);
    check("s2_writeback", issue_writeback_o, 0);
    tick();
    issue_valid_i = 1'b0;
    check("s2_not_queued", busy_o, 0);
    commit_valid_i = 1'b1; commit_id_i = 3'd5;
    tick();
    commit_valid_i = 1'b0;
    check("s2_commit_ignored_valid", acc_valid_o, 0);
    check("s2_commit_ignored_busy", busy_o, 0);

    // Fill the queue with same-cycle commits (bypass), stall dispatch
    acc_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_008B; issue_id_i = 3'(i);
      issue_rs1_i = 32'(100 + i); issue_rs2_i = 32'(200 + i);
      commit_valid_i = 1'b1; commit_id_i = 3'(i); commit_kill_i = 1'b0;
      settle();
      check("s3_fill_ready", issue_ready_o, 1);
      if (i == 0) check("s3_writeback", issue_writeback_o, 1);
      tick();
    end
    commit_valid_i = 1'b0;
    issue_id_i = 3'd4;
    settle();
    check("s3_full_custom_ready", issue_ready_o, 0);
    issue_instr_i = 32'h0000_0033;
    settle();
    check("s3_full_other_ready", issue_ready_o, 1);
    check("s3_full_other_accept", issue_accept_o, 0);
    tick();
    issue_valid_i = 1'b0;
    check("s3_head_valid", acc_valid_o, 1);
    check("s3_head_id", acc_id_o, 0);
    tick();
    check("s3_hold_valid", acc_valid_o, 1);
    check("s3_hold_id", acc_id_o, 0);
    check("s3_hold_rs1", acc_rs1_o, 100);
    acc_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("s3_drain_valid", acc_valid_o, 1);
      check("s3_drain_id", acc_id_o, 64'(i));
      check("s3_drain_rs2", acc_rs2_o, 64'(200 + i));
      tick();
    end
    check("s3_empty_valid", acc_valid_o, 0);
    check("s3_empty_busy", busy_o, 0);

    // Killed entry in the middle drains silently
    for (int i = 1; i <= 3; i++) begin
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_010B; issue_id_i = 3'(i);
      tick();
    end
    issue_valid_i = 1'b0;
    check("s4_uncommitted", acc_valid_o, 0);
    commit_valid_i = 1'b1; commit_id_i = 3'd6; commit_kill_i = 1'b0;
    tick();
    check("s4_stray_commit", acc_valid_o, 0);
    commit_id_i = 3'd1;
    tick();
    check("s4_id1_valid", acc_valid_o, 1);
    check("s4_id1", acc_id_o, 1);
    commit_id_i = 3'd2; commit_kill_i = 1'b1;
    tick();
    check("s4_kill_idle", acc_valid_o, 0);
    check("s4_kill_busy", busy_o, 1);
    commit_id_i = 3'd3; commit_kill_i = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    check("s4_id3_valid", acc_valid_o, 1);
    check("s4_id3", acc_id_o, 3);
    tick();
    check("s4_done_valid", acc_valid_o, 0);
    check("s4_done_busy", busy_o, 0);

    // Result stage: backpressure then back-to-back streaming
    result_ready_i = 1'b0;
    accres_valid_i = 1'b1; accres_id_i = 3'd4; accres_data_i = 32'hDEAD_BEEF; accres_we_i = 1'b1;
    settle();
    check("s5_accres_ready_empty", accres_ready_o, 1);
    tick();
    accres_id_i = 3'd5; accres_data_i = 32'h1000_0005; accres_we_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s5_hold_valid", result_valid_o, 1);
      check("s5_hold_id", result_id_o, 4);
      check("s5_hold_data", result_data_o, 32'hDEAD_BEEF);
      check("s5_hold_we", result_we_o, 1);
      check("s5_hold_accres_ready", accres_ready_o, 0);
      check("s5_hold_busy", busy_o, 1);
      tick();
    end
    result_ready_i = 1'b1;
    settle();
    check("s5_release_ready", accres_ready_o, 1);
    tick();
    check("s5_r5_id", result_id_o, 5);
    check("s5_r5_data", result_data_o, 32'h1000_0005);
    check("s5_r5_we", result_we_o, 0);
    accres_id_i = 3'd6; accres_data_i = 32'h1000_0006; accres_we_i = 1'b1;
    tick();
    check("s5_r6_valid", result_valid_o, 1);
    check("s5_r6_id", result_id_o, 6);
    check("s5_r6_data", result_data_o, 32'h1000_0006);
    accres_id_i = 3'd7; accres_data_i = 32'h1000_0007;
    tick();
    accres_valid_i = 1'b0;
    check("s5_r7_id", result_id_o, 7);
    check("s5_r7_data", result_data_o, 32'h1000_0007);
    tick();
    check("s5_drained", result_valid_o, 0);
    check("s5_idle", busy_o, 0);

    // Reset with three queued entries and a pending result
    acc_ready_i = 1'b0; result_ready_i = 1'b0;
    accres_valid_i = 1'b1; accres_id_i = 3'd3; accres_data_i = 32'h0000_ABCD; accres_we_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_008B; issue_id_i = 3'(i);
      commit_valid_i = 1'b1; commit_id_i = 3'(i); commit_kill_i = 1'b0;
      tick();
      accres_valid_i = 1'b0;
    end
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    check("s6_pre_acc_valid", acc_valid_o, 1);
    check("s6_pre_result_valid", result_valid_o, 1);
    check("s6_pre_busy", busy_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    check("s6_acc_valid", acc_valid_o, 0);
    check("s6_result_valid", result_valid_o, 0);
    check("s6_busy", busy_o, 0);
    check("s6_issue_ready", issue_ready_o, 1);
    acc_ready_i = 1'b1; result_ready_i = 1'b1;
    tick();
    check("s6_no_dispatch", acc_valid_o, 0);
    check("s6_no_result", result_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ma_cvxif_offload_queue.md
Name: ma_cvxif_offload_queue

Overview:
- Sits directly downstream of the CVA6 core on its CVXIF coprocessor port (CvxifEn=1, XLEN=32).
- Decodes offloaded instructions and accepts only custom-0 matrix opcodes.
- Buffers accepted instructions until the core commits them, then dispatches them in order to the matrix accelerator.
- Returns accelerator results to the core through a registered result stage.

Parameters:
- XLEN, 32, operand/result width (matches core XLEN).
- ID_W, 3, CVXIF instruction id width.
- DEPTH, 4, offload queue entries (power of 2, >=2).
- MA_OPCODE, 7'b0001011, major opcode accepted (custom-0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- issue_valid_i  in  1  core offers instruction
- issue_ready_o  out  1  handshake completes
- issue_instr_i  in  32  instruction word
- issue_rs1_i / issue_rs2_i  in  XLEN  operand values
- issue_id_i  in  ID_W  instruction id
- issue_accept_o  out  1  instruction is a coprocessor op
- issue_writeback_o  out  1  op will write rd
- commit_valid_i  in  1  commit event
- commit_id_i  in  ID_W  committed id
- commit_kill_i  in  1  discard instead of execute
- acc_valid_o / acc_ready_i  out/in  1  dispatch handshake to accelerator
- acc_instr_o  out  32  dispatched instruction
- acc_rs1_o / acc_rs2_o  out  XLEN  dispatched operands
- acc_id_o  out  ID_W  dispatched id
- accres_valid_i / accres_ready_o  in/out  1  accelerator result handshake
- accres_id_i  in  ID_W  result id
- accres_data_i  in  XLEN  result data
- accres_we_i  in  1  result writes rd
- result_valid_o / result_ready_i  out/in  1  result to core
- result_id_o / result_data_o / result_we_o  out  ID_W/XLEN/1  registered result
- busy_o  out  1  any entry or result pending

Behaviour:
- Reset (rst_ni=0 at posedge):
  - Pointers and count cleared; all entry flags cleared.
  - acc_valid_o=0, result_valid_o=0, busy_o=0.
  - Reset mid-operation drops all entries and any pending result, with no further handshakes.
- Decode is combinational:
  - accept = instr[6:0]==MA_OPCODE.
  - writeback = accept && instr[11:7]!=0.
- issue_ready_o = !accept || (count<DEPTH).
  - Rejected instructions complete in the same cycle and are never enqueued.
  - Readiness does not depend on a same-cycle pop, so there is no combinational path acc_ready_i -> issue_ready_o.
- Enqueue on issue_valid_i && issue_ready_o && accept. The stored entry holds {instr, rs1, rs2, id, committed=0, killed=0}.
- Commits arrive in order. A commit pointer tracks the oldest uncommitted entry.
  - If commit_valid_i and commit_id_i equals that entry's id: set committed, or killed if commit_kill_i=1, then advance the commit pointer.
  - A non-matching commit is ignored (it belongs to a rejected instruction).
  - Commit in the same cycle as enqueue of the same id into an empty commit slot is applied to the new entry (bypass).
- Dispatch:
  - acc_valid_o = head valid && committed && !killed.
  - Pop on acc_valid_o && acc_ready_i.
  - A killed head pops silently, one per cycle, without asserting acc_valid_o.
  - acc_* outputs hold stable while acc_valid_o && !acc_ready_i.
- Simultaneous enqueue and pop: count unchanged, both pointers advance and wrap modulo DEPTH.
- Result stage is a 1-entry register:
  - accres_ready_o = !result_valid_o || result_ready_i.
  - Latency is 1 cycle from accres handshake to result_valid_o.
  - Full throughput is supported when result_ready_i is held high.
- busy_o = (count!=0) || result_valid_o, registered-state derived.

Decomposition:
- Package ma_cvxif_pkg holds:
  - MA_OPCODE;
  - entry typedef ma_offload_entry_t {instr, rs1, rs2, id, committed, killed};
  - result typedef ma_result_t {id, data, we}.
- Sub-module ma_result_slice (1-entry valid/ready register, parameterized by type) implements the result path.

Test Plan:
- Issue 0x0000100B (custom-0, rd=0) with id=2, rs1=5, rs2=7, then commit id=2 kill=0, with acc_ready_i=1 -> accept=1, writeback=0; acc_valid_o one cycle after commit with acc_rs1_o=5, acc_rs2_o=7, acc_id_o=2.
- Issue 0x00000033 (ADD) -> issue_ready_o=1, accept=0 in the same cycle; count stays 0; a later commit for its id is ignored.
- Issue 4 custom ops with acc_ready_i=0 and all committed -> issue_ready_o drops for a 5th custom op; a non-custom op is still ready; raising acc_ready_i dispatches ids in order 0,1,2,3.
- Enqueue ids 1,2,3, commit 1 ok, 2 kill, 3 ok -> acc sees ids 1 and 3 only, with one idle cycle for the killed pop.
- accres id=4, data=0xDEADBEEF, we=1 while result_ready_i=0 for 3 cycles -> result held stable, accres_ready_o=0 until release; result_ready_i=1 then streams back-to-back results one per cycle.
- Assert rst_ni=0 for 1 cycle with 3 entries and a valid result -> next cycle acc_valid_o=0, result_valid_o=0, busy_o=0, issue_ready_o=1.
